dmembus_wbc_split: RTL and testbench
====================================

// Module: dmembus_wbc_split
// PURPOSE
//  Data-memory bus adapter between the CPU load/store stage and a Wishbone controller port.
//  Byte, halfword and word accesses are supported at any address.
//  Misaligned accesses that straddle a word boundary are split into two back-to-back Wishbone beats.
//  Load data is re-assembled, shifted and sign- or zero-extended.
//  Adds a bus-timeout watchdog. Successor of the aligned-only membus.
// PARAMETERS
//  ALLOW_MISALIGNED  1   1: split straddling accesses; 0: flag them on o_unaligned, no bus cycle
//  TIMEOUT_CYCLES    0   beats held longer than this many cycles without ack/err abort; 0 = never
//  TIMEOUT_W         16  width of the timeout counter; TIMEOUT_CYCLES must be < 2**TIMEOUT_W
// PORTS
//  i_clk             in   1   clock
//  i_rst             in   1   synchronous active-high reset
//  wb                ctrl -   Wishbone.Controller interface; wb.cyc = wb.stb
//  o_bus_width_hint  out  2   byte count of current beat minus 1 (0..3)
//  i_addr            in   32  byte address
//  i_data            in   32  store data, right-justified
//  i_width           in   2   01 = byte, 10 = half, 00/11 = word
//  i_we / i_re       in   1   store / load request; i_req = i_we|i_re, sampled only when o_stall=0
//  i_zeroextend      in   1   1 = zero-extend load, 0 = sign-extend
//  o_data            out  32  load result, valid the cycle o_stall falls
//  o_stall           out  1   access in flight
//  o_error           out  1   wb.err or timeout on the last access; cleared when a new access is accepted
//  o_timeout         out  1   last access aborted by the watchdog
//  o_unaligned       out  1   1-cycle pulse: straddling request rejected (ALLOW_MISALIGNED=0)
// BEHAVIOUR
//  Reset: state IDLE; wb.stb, o_stall, o_error, o_timeout, o_unaligned, o_data all 0; counter 0.
//  off = addr[1:0]; mask = 0001/0011/1111 by width; m8 = {4'b0,mask} << off.
//  Straddle = |m8[7:4]: word with off!=0, or half with off=3.
//  Write data rotated: wd = {32'b0,i_data} << 8*off.
//  FSM: IDLE -> BEAT0 -> (straddle ? BEAT1 : IDLE) -> IDLE.
//  IDLE, i_req, not rejected:
//   - Next edge: stb=1, o_stall=1, o_error=0, o_timeout=0.
//   - BEAT0 drives addr = {a[31:2],2'b00}, sel = m8[3:0], data = wd[31:0].
//   - Request fields (addr, width, zeroextend, we, wd) are registered.
//  BEAT0 ack, straddle:
//   - Capture data_rd as lo.
//   - Next edge: stay stb=1; addr += 4, sel = m8[7:4], data = wd[63:32].
//   - Entering BEAT1 forces one stb deassert cycle? No: stb stays high, only addr/sel/data change.
//  Final ack:
//   - Next edge: stb=0, o_stall=0.
//   - o_data = ext({hi,lo} >> 8*off); a non-split access uses lo = data_rd.
//   - Store: o_data is don't-care.
//  wb.err on any beat: next edge stb=0, o_stall=0, o_error=1; a pending BEAT1 is not issued.
//  Timeout:
//   - Counter clears at every beat start and counts cycles with stb=1.
//   - When counter == TIMEOUT_CYCLES: next edge stb=0, o_stall=0, o_error=1, o_timeout=1; FSM to IDLE.
//  o_bus_width_hint = popcount(sel) - 1 of the beat being driven.
//  Reject (ALLOW_MISALIGNED=0 and straddle):
//   - Next edge o_unaligned=1 for one cycle; no bus activity, o_stall stays 0.
//   - o_unaligned is also 0 every cycle with no request.
//  Latency:
//   - Aligned access: request cycle N, stb from N+1, ack at cycle K, o_stall low at K+1.
//   - Split access: two acks, so add the BEAT1 ack wait.
//  Requests while o_stall=1 are ignored (VERIFICATION build: $error).
//  A new request is legal in the cycle o_stall first falls.
//  Reset mid-access: next edge stb=0 and all outputs at reset values; a late ack is ignored.
//  ack and err together: treated as err.
// TESTING
//  1. lw 0x100, mem word 0x8899AABB:
//     -> one beat, sel=1111, o_data=0x8899AABB, o_stall high exactly 2 cycles with 1-cycle ack.
//  2. lh 0x102, word 0x80FF0000, zeroextend=0:
//     -> sel=1100, o_data=0xFFFF80FF; same with zeroextend=1 -> 0x000080FF.
//  3. sw 0x1DE data 0x11223344:
//     -> beat0 addr 0x1DC sel=1100 data 0x33440000;
//     -> beat1 addr 0x1E0 sel=0011 data 0x00001122.
//  4. lw 0x103, lo=0xAABBCCDD, hi=0x11223344:
//     -> o_data=0x223344AA; wb.err on beat0 -> no beat1, o_error=1.
//  5. TIMEOUT_CYCLES=4, slave never acks:
//     -> stb drops after 4 stall cycles, o_error=o_timeout=1; next access clears both.
//  6. ALLOW_MISALIGNED=0, lh 0x003:
//     -> o_unaligned 1-cycle pulse, stb never rises; i_rst during beat -> stb=0 next edge.

Source files
------------

// File: rtl/dmembus_wbc_split.sv
// Data-memory bus adapter between the CPU load/store stage and a Wishbone controller port.
// Accesses straddling a word boundary become two back-to-back beats; load data is realigned and extended.
module dmembus_wbc_split #(
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES   = 0,
  parameter int unsigned TIMEOUT_W        = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic [1:0]  o_bus_width_hint,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_width,
  input  logic        i_we,
  input  logic        i_re,
  input  logic        i_zeroextend,
  output logic [31:0] o_data,
  output logic        o_stall,
  output logic        o_error,
  output logic        o_timeout,
  output logic        o_unaligned
);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;

  localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [31:0] extend_load(input logic [31:0] v, input logic [1:0] w,
                                              input logic zx);
    case (w)
      2'b01:   extend_load = zx ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b10:   extend_load = zx ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: extend_load = v;
    endcase
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] s);
    popcount4 = {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
  endfunction

  state_t               state_q, state_d;
  logic [3:0]           req_mask;
  logic [7:0]           req_m8;
  logic [63:0]          req_wd;
  logic                 req, req_straddle, reject, accept;
  logic [29:0]          addr_q;
  logic [1:0]           off_q, width_q;
  logic                 zext_q, we_q;
  logic [7:0]           m8_q;
  logic [63:0]          wd_q;
  logic [31:0]          lo_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 err_q, tmo_q, unal_q;
  logic [31:0]          rdata_q;
  logic                 stb, beat1, straddle_q;
  logic                 resp_ack, resp_err, tmo_hit, final_ack;
  logic [3:0]           beat_sel;
  logic [63:0]          rd_pair;
  logic [31:0]          rd_word;

  always_comb begin
    case (i_width)
      2'b01:   req_mask = 4'b0001;
      2'b10:   req_mask = 4'b0011;
      default: req_mask = 4'b1111;
    endcase
    req_m8       = {4'b0000, req_mask} << i_addr[1:0];
    req_wd       = {32'h0, i_data} << {i_addr[1:0], 3'b000};
    req_straddle = |req_m8[7:4];
    req          = i_we | i_re;
    reject       = (state_q == IDLE) && req && req_straddle && !ALLOW_MISALIGNED;
    accept       = (state_q == IDLE) && req && !(req_straddle && !ALLOW_MISALIGNED);
  end

  // err wins over a simultaneous ack; a response in the last allowed cycle beats the watchdog
  assign stb        = (state_q != IDLE);
  assign beat1      = (state_q == BEAT1);
  assign straddle_q = |m8_q[7:4];
  assign resp_err   = stb && i_wb_err;
  assign resp_ack   = stb && i_wb_ack && !i_wb_err;
  assign tmo_hit    = TMO_EN && stb && !i_wb_ack && !i_wb_err && (cnt_q == TMO_LAST);
  assign final_ack  = resp_ack && (beat1 || !straddle_q);
  assign beat_sel   = beat1 ? m8_q[7:4] : m8_q[3:0];
  assign rd_pair    = beat1 ? {i_wb_dat, lo_q} : {32'h0, i_wb_dat};
  assign rd_word    = 32'(rd_pair >> {off_q, 3'b000});

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BEAT0;
      BEAT0: begin
        if (resp_err || tmo_hit) state_d = IDLE;
        else if (resp_ack)       state_d = straddle_q ? BEAT1 : IDLE;
      end
      BEAT1:   if (resp_err || tmo_hit || resp_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_wb_stb         = stb;
    o_wb_cyc         = stb;
    o_stall          = stb;
    o_wb_we          = stb & we_q;
    o_wb_adr         = 32'h0;
    o_wb_sel         = 4'h0;
    o_wb_dat         = 32'h0;
    o_bus_width_hint = 2'b00;
    if (stb) begin
      o_wb_adr         = {addr_q + {29'd0, beat1}, 2'b00};
      o_wb_sel         = beat_sel;
      o_wb_dat         = beat1 ? wd_q[63:32] : wd_q[31:0];
      o_bus_width_hint = 2'(popcount4(beat_sel) - 3'd1);
    end
  end

  // the watchdog counter restarts whenever a new beat begins
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      unal_q  <= 1'b0;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      unal_q <= reject;
      if (accept) begin
        err_q <= 1'b0;
        tmo_q <= 1'b0;
        cnt_q <= '0;
      end else if (stb) begin
        if (resp_ack && !final_ack) cnt_q <= '0;
        else                        cnt_q <= cnt_q + 1'b1;
        if (resp_err || tmo_hit) err_q <= 1'b1;
        if (tmo_hit)             tmo_q <= 1'b1;
      end
      if (final_ack && !we_q) rdata_q <= extend_load(rd_word, width_q, zext_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_q  <= i_addr[31:2];
      off_q   <= i_addr[1:0];
      width_q <= i_width;
      zext_q  <= i_zeroextend;
      we_q    <= i_we;
      m8_q    <= req_m8;
      wd_q    <= req_wd;
    end
    if ((state_q == BEAT0) && resp_ack) lo_q <= i_wb_dat;
  end

  assign o_data      = rdata_q;
  assign o_error     = err_q;
  assign o_timeout   = tmo_q;
  assign o_unaligned = unal_q;

`ifdef VERIFICATION
  always_ff @(posedge i_clk) begin
    if (!i_rst && o_stall && (i_we || i_re)) $error("request issued while o_stall is high");
  end
`endif

endmodule

// File: tb/tb_dmembus_wbc_split.sv
// Bench for dmembus_wbc_split: byte-addressed reference memory, scripted scenarios and random traffic.
module tb_dmembus_wbc_split;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_addr = 32'h0, i_data = 32'h0;
  logic [1:0]  i_width = 2'b00;
  logic        i_we = 1'b0, i_re = 1'b0, i_zx = 1'b0;

  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [31:0] wb_adr, wb_dato, wb_dati;
  logic [3:0]  wb_sel;
  logic [1:0]  wb_hint;
  logic [31:0] o_data;
  logic        o_stall, o_error, o_timeout, o_unal;

  logic        r_cyc, r_stb, r_we;
  logic [31:0] r_adr, r_dato, r_data;
  logic [3:0]  r_sel;
  logic [1:0]  r_hint;
  logic        r_stall, r_error, r_timeout, r_unal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmembus_wbc_split #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(4), .TIMEOUT_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_sel(wb_sel), .o_wb_dat(wb_dato), .i_wb_dat(wb_dati), .i_wb_ack(wb_ack),
    .i_wb_err(wb_err), .o_bus_width_hint(wb_hint),
    .i_addr(i_addr), .i_data(i_data), .i_width(i_width), .i_we(i_we), .i_re(i_re),
    .i_zeroextend(i_zx), .o_data(o_data), .o_stall(o_stall), .o_error(o_error),
    .o_timeout(o_timeout), .o_unaligned(o_unal));

  dmembus_wbc_split #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(0), .TIMEOUT_W(16)) dut_r (
    .i_clk(clk), .i_rst(rst),
    .o_wb_cyc(r_cyc), .o_wb_stb(r_stb), .o_wb_we(r_we), .o_wb_adr(r_adr),
    .o_wb_sel(r_sel), .o_wb_dat(r_dato), .i_wb_dat(32'h0), .i_wb_ack(r_stb),
    .i_wb_err(1'b0), .o_bus_width_hint(r_hint),
    .i_addr(i_addr), .i_data(i_data), .i_width(i_width), .i_we(i_we), .i_re(i_re),
    .i_zeroextend(i_zx), .o_data(r_data), .o_stall(r_stall), .o_error(r_error),
    .o_timeout(r_timeout), .o_unaligned(r_unal));

  // Wishbone slave: 1 KB memory, configurable wait states, error injection and hang
  logic [31:0] mem [0:255];
  logic [31:0] log_adr [0:1023];
  logic [31:0] log_dat [0:1023];
  logic [3:0]  log_sel [0:1023];
  logic [1:0]  log_hint [0:1023];
  int  nlog = 0;
  int  wcnt = 0, bidx = 0;
  int  slv_wait = 0, slv_err_beat = -1;
  bit  slv_hang = 1'b0, slv_force_ack = 1'b0;
  logic resp;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  assign resp    = wb_stb && !slv_hang && (wcnt == slv_wait);
  assign wb_err  = resp && (bidx == slv_err_beat);
  assign wb_ack  = (resp && (bidx != slv_err_beat)) || slv_force_ack;
  assign wb_dati = mem[wb_adr[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      wcnt <= 0;
      bidx <= 0;
    end else if (!wb_stb) begin
      wcnt <= 0;
      bidx <= 0;
    end else if (wb_ack || wb_err) begin
      wcnt <= 0;
      bidx <= bidx + 1;
      log_adr[nlog % 1024]  <= wb_adr;
      log_dat[nlog % 1024]  <= wb_dato;
      log_sel[nlog % 1024]  <= wb_sel;
      log_hint[nlog % 1024] <= wb_hint;
      nlog <= nlog + 1;
      if (wb_ack && wb_we)
        for (int b = 0; b < 4; b++)
          if (wb_sel[b]) mem[wb_adr[9:2]][8*b +: 8] <= wb_dato[8*b +: 8];
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // reference model: little-endian byte memory
  logic [7:0] refb [0:1023];

  task automatic ref_init();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) refb[4*i + b] = w[8*b +: 8];
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b01) ? 1 : (w == 2'b10) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input bit zx);
    int n;
    logic [31:0] v;
    n = nbytes(w);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = refb[(int'(a[9:0]) + i) % 1024];
    if (!zx && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    for (int i = 0; i < nbytes(w); i++) refb[(int'(a[9:0]) + i) % 1024] = d[8*i +: 8];
  endtask

  task automatic access(input bit we, input logic [31:0] a, input logic [1:0] w,
                        input logic [31:0] d, input bit zx, output int stall);
    @(negedge clk);
    i_addr = a; i_data = d; i_width = w; i_we = we; i_re = !we; i_zx = zx;
    @(posedge clk); #1;
    i_we = 1'b0; i_re = 1'b0;
    stall = 0;
    while (o_stall && stall < 50) begin
      stall++;
      @(posedge clk); #1;
    end
    if (o_stall) begin
      checks++; errors++;
      $display("FAIL access_bound: o_stall=%0b after %0d cycles, required 0", o_stall, stall);
    end
    if (we && !o_error) ref_store(a, w, d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wb_stb !== 1'b0)    begin errors++; $display("FAIL reset_stb got=%b exp=0", wb_stb); end
    checks++; if (o_stall !== 1'b0)   begin errors++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
    checks++; if (o_error !== 1'b0)   begin errors++; $display("FAIL reset_error got=%b exp=0", o_error); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", o_timeout); end
    checks++; if (o_unal !== 1'b0)    begin errors++; $display("FAIL reset_unal got=%b exp=0", o_unal); end
    checks++; if (o_data !== 32'h0)   begin errors++; $display("FAIL reset_data got=%h exp=0", o_data); end
    rst = 1'b0;
    ref_init();
  endtask

  task automatic test_aligned_word();
    int st, start;
    slv_wait = 1;
    access(1'b1, 32'h100, 2'b00, 32'h8899AABB, 1'b0, st);
    checks++; if (st !== 2) begin errors++; $display("FAIL sw_stall got=%0d exp=2", st); end
    start = nlog;
    access(1'b0, 32'h100, 2'b00, 32'h0, 1'b0, st);
    checks++; if (o_data !== 32'h8899AABB) begin errors++; $display("FAIL lw_data got=%h exp=8899aabb", o_data); end
    checks++; if (st !== 2) begin errors++; $display("FAIL lw_stall got=%0d exp=2", st); end
    checks++; if (log_sel[start % 1024] !== 4'b1111) begin errors++; $display("FAIL lw_sel got=%b exp=1111", log_sel[start % 1024]); end
    checks++; if (log_hint[start % 1024] !== 2'd3) begin errors++; $display("FAIL lw_hint got=%0d exp=3", log_hint[start % 1024]); end
  endtask

  task automatic test_half_ext();
    int st, start;
    slv_wait = 0;
    access(1'b1, 32'h100, 2'b00, 32'h80FF0000, 1'b0, st);
    start = nlog;
    access(1'b0, 32'h102, 2'b10, 32'h0, 1'b0, st);
    checks++; if (o_data !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_sext got=%h exp=ffff80ff", o_data); end
    checks++; if (log_sel[start % 1024] !== 4'b1100) begin errors++; $display("FAIL lh_sel got=%b exp=1100", log_sel[start % 1024]); end
    access(1'b0, 32'h102, 2'b10, 32'h0, 1'b1, st);
    checks++; if (o_data !== 32'h000080FF) begin errors++; $display("FAIL lh_zext got=%h exp=000080ff", o_data); end
    access(1'b0, 32'h103, 2'b01, 32'h0, 1'b0, st);
    checks++; if (o_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got=%h exp=ffffff80", o_data); end
  endtask

  task automatic test_split_store();
    int st, start;
    slv_wait = 0;
    start = nlog;
    access(1'b1, 32'h1DE, 2'b00, 32'h11223344, 1'b0, st);
    checks++; if (st !== 2) begin errors++; $display("FAIL sw_split_stall got=%0d exp=2", st); end
    checks++; if (log_adr[start % 1024] !== 32'h1DC) begin errors++; $display("FAIL b0_adr got=%h exp=000001dc", log_adr[start % 1024]); end
    checks++; if (log_sel[start % 1024] !== 4'b1100) begin errors++; $display("FAIL b0_sel got=%b exp=1100", log_sel[start % 1024]); end
    checks++; if (log_dat[start % 1024] !== 32'h33440000) begin errors++; $display("FAIL b0_dat got=%h exp=33440000", log_dat[start % 1024]); end
    checks++; if (log_adr[(start+1) % 1024] !== 32'h1E0) begin errors++; $display("FAIL b1_adr got=%h exp=000001e0", log_adr[(start+1) % 1024]); end
    checks++; if (log_sel[(start+1) % 1024] !== 4'b0011) begin errors++; $display("FAIL b1_sel got=%b exp=0011", log_sel[(start+1) % 1024]); end
    checks++; if (log_dat[(start+1) % 1024] !== 32'h00001122) begin errors++; $display("FAIL b1_dat got=%h exp=00001122", log_dat[(start+1) % 1024]); end
  endtask

  task automatic test_split_load_err();
    int st, start;
    slv_wait = 1;
    access(1'b1, 32'h100, 2'b00, 32'hAABBCCDD, 1'b0, st);
    access(1'b1, 32'h104, 2'b00, 32'h11223344, 1'b0, st);
    access(1'b0, 32'h103, 2'b00, 32'h0, 1'b0, st);
    checks++; if (o_data !== 32'h223344AA) begin errors++; $display("FAIL lw_split_data got=%h exp=223344aa", o_data); end
    checks++; if (st !== 4) begin errors++; $display("FAIL lw_split_stall got=%0d exp=4", st); end
    slv_err_beat = 0;
    start = nlog;
    access(1'b0, 32'h103, 2'b00, 32'h0, 1'b0, st);
    checks++; if (o_error !== 1'b1) begin errors++; $display("FAIL err0_error got=%b exp=1", o_error); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL err0_timeout got=%b exp=0", o_timeout); end
    checks++; if (nlog - start !== 1) begin errors++; $display("FAIL err0_beats got=%0d exp=1", nlog - start); end
    checks++; if (st !== 2) begin errors++; $display("FAIL err0_stall got=%0d exp=2", st); end
    slv_err_beat = 1;
    access(1'b0, 32'h103, 2'b00, 32'h0, 1'b0, st);
    checks++; if (o_error !== 1'b1 || st !== 4) begin errors++; $display("FAIL err1 got error=%b stall=%0d exp error=1 stall=4", o_error, st); end
    slv_err_beat = -1;
    access(1'b0, 32'h100, 2'b00, 32'h0, 1'b0, st);
    checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", o_error); end
    checks++; if (o_data !== 32'hAABBCCDD) begin errors++; $display("FAIL err_after_data got=%h exp=aabbccdd", o_data); end
  endtask

  task automatic test_timeout();
    int st, start;
    slv_hang = 1'b1;
    start = nlog;
    access(1'b0, 32'h100, 2'b00, 32'h0, 1'b0, st);
    checks++; if (st !== 4) begin errors++; $display("FAIL tmo_stall got=%0d exp=4", st); end
    checks++; if (o_error !== 1'b1 || o_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flags got err=%b tmo=%b exp 1 1", o_error, o_timeout); end
    checks++; if (nlog - start !== 0) begin errors++; $display("FAIL tmo_beats got=%0d exp=0", nlog - start); end
    slv_hang = 1'b0;
    slv_wait = 0;
    access(1'b0, 32'h104, 2'b00, 32'h0, 1'b0, st);
    checks++; if (o_error !== 1'b0 || o_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear got err=%b tmo=%b exp 0 0", o_error, o_timeout); end
    checks++; if (o_data !== 32'h11223344) begin errors++; $display("FAIL tmo_after_data got=%h exp=11223344", o_data); end
  endtask

  task automatic test_reject();
    int g;
    slv_wait = 0;
    checks++; if (r_unal !== 1'b0) begin errors++; $display("FAIL rej_idle got=%b exp=0", r_unal); end
    @(negedge clk);
    i_addr = 32'h003; i_width = 2'b10; i_re = 1'b1; i_zx = 1'b0;
    @(posedge clk); #1;
    i_re = 1'b0;
    checks++; if (r_unal !== 1'b1) begin errors++; $display("FAIL rej_pulse got=%b exp=1", r_unal); end
    checks++; if (r_stb !== 1'b0 || r_stall !== 1'b0) begin errors++; $display("FAIL rej_bus got stb=%b stall=%b exp 0 0", r_stb, r_stall); end
    @(posedge clk); #1;
    checks++; if (r_unal !== 1'b0 || r_stb !== 1'b0) begin errors++; $display("FAIL rej_after got unal=%b stb=%b exp 0 0", r_unal, r_stb); end
    g = 0;
    while (o_stall && g < 20) begin g++; @(posedge clk); #1; end
    @(negedge clk);
    i_addr = 32'h002; i_width = 2'b10; i_re = 1'b1;
    @(posedge clk); #1;
    i_re = 1'b0;
    checks++; if (r_stb !== 1'b1 || r_unal !== 1'b0) begin errors++; $display("FAIL rej_aligned got stb=%b unal=%b exp 1 0", r_stb, r_unal); end
    checks++; if (r_sel !== 4'b1100 || r_hint !== 2'd1) begin errors++; $display("FAIL rej_aligned_sel got sel=%b hint=%0d exp 1100 1", r_sel, r_hint); end
    g = 0;
    while ((o_stall || r_stall) && g < 20) begin g++; @(posedge clk); #1; end
  endtask

  task automatic test_random();
    int st, n, off, beats, start, bad;
    logic [31:0] a, d, expv, w32;
    logic [1:0] w;
    bit we, zx;
    for (int k = 0; k < 150; k++) begin
      we = 1'($urandom_range(0, 1)); w = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 1023)); d = $urandom; zx = 1'($urandom_range(0, 1));
      slv_wait = $urandom_range(0, 2);
      n = nbytes(w); off = int'(a[1:0]); beats = (off + n > 4) ? 2 : 1;
      expv = ref_load(a, w, zx);
      start = nlog;
      access(we, a, w, d, zx, st);
      checks++; if (st !== beats * (slv_wait + 1)) begin errors++; $display("FAIL rnd_stall a=%h got=%0d exp=%0d", a, st, beats * (slv_wait + 1)); end
      checks++; if (nlog - start !== beats) begin errors++; $display("FAIL rnd_beats a=%h got=%0d exp=%0d", a, nlog - start, beats); end
      checks++; if (log_hint[start % 1024] !== 2'(((n < 4 - off) ? n : 4 - off) - 1)) begin errors++; $display("FAIL rnd_hint a=%h w=%b got=%0d", a, w, log_hint[start % 1024]); end
      checks++; if (log_adr[start % 1024] !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd_adr got=%h exp=%h", log_adr[start % 1024], {a[31:2], 2'b00}); end
      checks++; if (o_error !== 1'b0) begin errors++; $display("FAIL rnd_error a=%h got=%b exp=0", a, o_error); end
      if (!we) begin
        checks++; if (o_data !== expv) begin errors++; $display("FAIL rnd_load a=%h w=%b zx=%b got=%h exp=%h", a, w, zx, o_data, expv); end
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      for (int b = 0; b < 4; b++) w32[8*b +: 8] = refb[4*i + b];
      if (mem[i] !== w32) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mem_compare got=%0d differing words exp=0", bad); end
  endtask

  task automatic test_reset_mid_access();
    int st;
    slv_hang = 1'b1;
    @(negedge clk);
    i_addr = 32'h100; i_width = 2'b00; i_re = 1'b1;
    @(posedge clk); #1;
    i_re = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (wb_stb !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL rstmid_bus got stb=%b stall=%b exp 0 0", wb_stb, o_stall); end
    checks++; if (o_data !== 32'h0 || o_error !== 1'b0 || wb_hint !== 2'd0) begin errors++; $display("FAIL rstmid_out got data=%h err=%b width=%0d exp 0", o_data, o_error, wb_hint); end
    rst = 1'b0;
    slv_hang = 1'b0;
    ref_init();
    @(negedge clk);
    slv_force_ack = 1'b1;
    @(posedge clk); #1;
    slv_force_ack = 1'b0;
    checks++; if (o_stall !== 1'b0 || wb_stb !== 1'b0 || o_error !== 1'b0) begin errors++; $display("FAIL late_ack got stall=%b stb=%b err=%b exp 0", o_stall, wb_stb, o_error); end
    slv_wait = 0;
    access(1'b0, 32'h100, 2'b00, 32'h0, 1'b0, st);
    checks++; if (o_data !== init_word(32'h40)) begin errors++; $display("FAIL rstmid_reload got=%h exp=%h", o_data, init_word(32'h40)); end
  endtask

  initial begin
    test_reset();
    test_aligned_word();
    test_half_ext();
    test_split_store();
    test_split_load_err();
    test_timeout();
    test_reject();
    test_random();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

endmodule
